// File: rtl/conv1d_mac_ctrl_if.sv
// Stream and coefficient-bus bundle for the 1-D convolution MAC sequencer.
// master = sample source / result sink side, slave = the sequencer.
interface conv1d_mac_ctrl_if #(
    parameter int DW   = 8,
    parameter int TAPS = 4
);
    localparam int AW = 2 * DW + $clog2(TAPS);

    logic                     in_valid;
    logic                     in_ready;
    logic [DW-1:0]            in_data;
    logic                     coef_we;
    logic [$clog2(TAPS)-1:0]  coef_addr;
    logic [DW-1:0]            coef_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [AW-1:0]            out_data;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/conv1d_mac_ctrl.sv
// Sequences an external 18-bit accumulator through clear + TAPS MAC steps per
// accepted sample and returns y[n] = sum coef[k]*x[n-k] on an output stream.
module conv1d_mac_ctrl #(
    parameter  int TAPS = 4,
    parameter  int DW   = 8,
    localparam int AW   = 2 * DW + $clog2(TAPS),
    localparam int CW   = $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    conv1d_mac_ctrl_if.slave     bus,
    output logic [2*DW-1:0]      acc_data_a_o,
    output logic                 clear_acc_o,
    output logic                 en_acc_o,
    input  logic [AW-1:0]        acc_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC,
        DRAIN,
        HOLD
    } state_t;

    state_t                 state;
    logic signed [DW-1:0]   window [TAPS];
    logic signed [DW-1:0]   coef   [TAPS];
    logic [CW-1:0]          cnt;
    logic signed [2*DW-1:0] prod;

    // Both operands sign-extended to the product width so the multiply is signed.
    assign prod = (2*DW)'(window[cnt]) * (2*DW)'(coef[cnt]);

    assign bus.in_ready = (state == IDLE);
    assign clear_acc_o  = (state == CLEAR);
    assign en_acc_o     = (state == MAC);
    assign acc_data_a_o = (state == MAC) ? prod : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            for (int k = 0; k < TAPS; k++) begin
                window[k] <= '0;
                coef[k]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A coefficient write in the accept cycle lands before the MAC uses it.
                    if (bus.coef_we) begin
                        coef[bus.coef_addr] <= bus.coef_data;
                    end
                    if (bus.in_valid) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            window[k] <= window[k-1];
                        end
                        window[0] <= bus.in_data;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt   <= '0;
                    state <= MAC;
                end
                MAC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(TAPS - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    bus.out_data  <= acc_data_i;
                    bus.out_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1d_mac_ctrl.sv
// Bench for conv1d_mac_ctrl: directed vector table, multi-cycle corner sequences
// and randomized samples checked against a direct convolution model.
module tb_conv1d_mac_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] acc_data_a;
    logic        clear_acc;
    logic        en_acc;
    logic [17:0] acc;

    conv1d_mac_ctrl_if #(.DW(8), .TAPS(4)) bus ();

    conv1d_mac_ctrl #(.TAPS(4), .DW(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .acc_data_a_o (acc_data_a),
        .clear_acc_o  (clear_acc),
        .en_acc_o     (en_acc),
        .acc_data_i   (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the team's registered 18-bit accumulator.
    always_ff @(posedge clk) begin
        if (reset)          acc <= '0;
        else if (clear_acc) acc <= '0;
        else if (en_acc)    acc <= acc + {{2{acc_data_a[15]}}, acc_data_a};
    end

    int vectors    = 0;
    int miscompares = 0;
    bit rdy_default = 1'b1;

    int hist [4];
    int cm   [4];

    typedef struct {
        bit          rst;
        int          c0, c1, c2, c3;
        int          x;
        logic [17:0] y;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [17:0] modelPush(input int x);
        int s;
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        s = 0;
        for (int k = 0; k < 4; k++) s += cm[k] * hist[k];
        return 18'(s);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.out_ready = rdy_default;
        repeat (2) tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            hist[k] = 0;
            cm[k]   = 0;
        end
    endtask

    task automatic writeCoef(input int addr, input int val);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'(addr);
        bus.coef_data = 8'(val);
        tick();
        bus.coef_we = 1'b0;
        cm[addr]    = val;
    endtask

    task automatic sendSample(input int x, output logic [17:0] exp_y);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(x);
        n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        exp_y = modelPush(x);
    endtask

    task automatic getResult(input int stall, output logic [17:0] data, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) checkOutput("result_timeout", 32'd0, 32'd1);
        data = bus.out_data;
        if (!bus.out_ready) repeat (stall) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = rdy_default;
    endtask

    task automatic applyStimulus(input int x, input int stall, output logic [17:0] got,
                                 output logic [17:0] exp_y, output int lat);
        sendSample(x, exp_y);
        getResult(stall, got, lat);
    endtask

    initial begin
        logic [17:0] got, exp_y, held, e2;
        int          lat, n;
        bit          stable;

        tbl[0] = '{1'b1,    1,    2,    3,    4,    1, 18'd1};
        tbl[1] = '{1'b0,    1,    2,    3,    4,    0, 18'd2};
        tbl[2] = '{1'b0,    1,    2,    3,    4,    0, 18'd3};
        tbl[3] = '{1'b0,    1,    2,    3,    4,    0, 18'd4};
        tbl[4] = '{1'b0,   -1,    0,    0,    0,    5, 18'h3FFFB};
        tbl[5] = '{1'b1, -128, -128, -128, -128, -128, 18'd16384};
        tbl[6] = '{1'b0, -128, -128, -128, -128, -128, 18'd32768};
        tbl[7] = '{1'b0, -128, -128, -128, -128, -128, 18'd49152};
        tbl[8] = '{1'b0, -128, -128, -128, -128, -128, 18'h10000};

        doReset();
        checkOutput("rst_in_ready",   32'(bus.in_ready),  32'd1);
        checkOutput("rst_out_valid",  32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data",   32'(bus.out_data),  32'd0);
        checkOutput("rst_en_acc",     32'(en_acc),        32'd0);
        checkOutput("rst_clear_acc",  32'(clear_acc),     32'd0);
        checkOutput("rst_acc_addend", 32'(acc_data_a),    32'd0);

        // Latency counted in edges after the accept edge: valid is seen after edge t+TAPS+2.
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst) doReset();
            writeCoef(0, tbl[i].c0);
            writeCoef(1, tbl[i].c1);
            writeCoef(2, tbl[i].c2);
            writeCoef(3, tbl[i].c3);
            applyStimulus(tbl[i].x, 0, got, exp_y, lat);
            checkOutput($sformatf("tbl%0d_data", i), 32'(got), 32'(tbl[i].y));
            checkOutput($sformatf("tbl%0d_latency", i), 32'(lat), 32'd6);
        end

        // Backpressure with a second sample waiting on in_valid.
        doReset();
        for (int k = 0; k < 4; k++) writeCoef(k, 1);
        rdy_default   = 1'b0;
        bus.out_ready = 1'b0;
        sendSample(10, exp_y);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        held         = bus.out_data;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd20;
        stable       = 1'b1;
        repeat (10) begin
            tick();
            if (!bus.out_valid || bus.out_data !== held || bus.in_ready) stable = 1'b0;
        end
        checkOutput("bp_stable", 32'(stable), 32'd1);
        checkOutput("bp_data", 32'(held), 32'(exp_y));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("bp_single_xfer", 32'(bus.out_valid), 32'd0);
        checkOutput("bp_ready_next", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        e2 = modelPush(20);
        checkOutput("bp_held_accepted", 32'(bus.in_ready), 32'd0);
        rdy_default   = 1'b1;
        bus.out_ready = 1'b1;
        getResult(0, got, lat);
        checkOutput("bp_second_data", 32'(got), 32'(e2));
        checkOutput("bp_second_latency", 32'(lat), 32'd6);

        // Coefficient write attempted during MAC must be dropped.
        doReset();
        writeCoef(0, 2);
        sendSample(3, exp_y);
        tick();
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'd0;
        bus.coef_data = 8'd7;
        tick();
        bus.coef_we = 1'b0;
        getResult(0, got, lat);
        checkOutput("gate_first", 32'(got), 32'd6);
        applyStimulus(4, 0, got, exp_y, lat);
        checkOutput("gate_ignored", 32'(got), 32'd8);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'd0;
        bus.coef_data = 8'd7;
        cm[0]         = 7;
        sendSample(1, exp_y);
        bus.coef_we = 1'b0;
        getResult(0, got, lat);
        checkOutput("gate_idle_write", 32'(got), 32'd7);

        // Reset landing in the second MAC cycle.
        sendSample(5, exp_y);
        tick();
        tick();
        checkOutput("rst_mid_en_before", 32'(en_acc), 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_mid_en_acc", 32'(en_acc), 32'd0);
        checkOutput("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            hist[k] = 0;
            cm[k]   = 0;
        end
        stable = 1'b1;
        repeat (8) begin
            tick();
            if (bus.out_valid) stable = 1'b0;
        end
        checkOutput("rst_mid_no_result", 32'(stable), 32'd1);
        writeCoef(0, 1);
        applyStimulus(9, 0, got, exp_y, lat);
        checkOutput("rst_mid_after", 32'(got), 32'd9);

        // Randomized samples, coefficient updates and sink stalls.
        doReset();
        for (int k = 0; k < 4; k++) writeCoef(k, int'($urandom_range(0, 255)) - 128);
        rdy_default   = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0)
                writeCoef(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128);
            applyStimulus(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)),
                          got, exp_y, lat);
            checkOutput($sformatf("rand%0d_data", i), 32'(got), 32'(exp_y));
            checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'd6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
